// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: sequential PC generation, one-cycle SRAM reads,
// and a small FIFO of {pc, inst} pairs handed to decode; branches flush and redirect.
module inst_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic                     clk,
    input  logic                     resetn,
    output logic                     inst_sram_en,
    output logic [3:0]               inst_sram_we,
    output logic [31:0]              inst_sram_addr,
    output logic [31:0]              inst_sram_wdata,
    input  logic [31:0]              inst_sram_rdata,
    input  logic                     ID_allow_in,
    output logic                     IF_to_ID_valid,
    output logic [63:0]              to_ID_data,
    input  logic                     br_taken,
    input  logic [31:0]              br_target,
    output logic [$clog2(DEPTH):0]   fq_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [31:0]       fetch_pc_q, fetch_pc_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_pc_q, rsp_pc_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [63:0]       mem_q [DEPTH];

    logic [CNT_W-1:0]  occupancy;
    logic              issue;
    logic              push;
    logic              head_valid;
    logic              pop;

    // Issue only when the queue can absorb every outstanding read; a same-cycle pop is not credited.
    always_comb begin
        occupancy  = count_q + CNT_W'(rsp_valid_q);
        issue      = resetn & ~br_taken & (occupancy < CNT_W'(DEPTH));
        push       = rsp_valid_q & ~br_taken;
        head_valid = (count_q != '0) & ~br_taken;
        pop        = head_valid & ID_allow_in;

        fetch_pc_d  = fetch_pc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_pc_d    = rsp_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;

        if (br_taken) begin
            fetch_pc_d  = {br_target[31:2], 2'b00};
            rsp_valid_d = 1'b0;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
        end else begin
            rsp_valid_d = issue;
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                rsp_pc_d   = fetch_pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc_q  <= RESET_PC;
            rsp_valid_q <= 1'b0;
            rsp_pc_q    <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_pc_q    <= rsp_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    // Queue storage; cleared on reset so the head reads zero until the first push.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= {rsp_pc_q, inst_sram_rdata};
        end
    end

    assign inst_sram_en    = issue;
    assign inst_sram_we    = 4'b0000;
    assign inst_sram_addr  = {fetch_pc_q[31:2], 2'b00};
    assign inst_sram_wdata = 32'd0;
    assign IF_to_ID_valid  = head_valid;
    assign to_ID_data      = mem_q[rd_ptr_q];
    assign fq_count        = count_q;

endmodule
